// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Clocked data memory for the MEM stage with a req/ack port,
//               byte-lane writes, post-reset auto-clear and range flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ack,
    output logic                  err,
    output logic                  ready
);

    localparam int                 c_LANES    = DATA_W / 8;
    localparam int                 c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]    c_DEPTH_EX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_RUN;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_clr_ptr;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_ack;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_mem_we;
    logic [c_IDX_W-1:0]   w_mem_idx;
    logic [DATA_W-1:0]    w_mem_wdata;
    logic [c_LANES-1:0]   w_mem_be;

    // Compare one bit wider so DEPTH == 2**ADDR_W needs no special case
    assign w_in_range = ({1'b0, addr} < c_DEPTH_EX);
    assign w_accept   = req && (r_state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_RESET_STATE;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == c_LAST) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = c_RESET_STATE;
        endcase
    end

    // The single write port is shared between the clear sweep and user writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = addr[c_IDX_W-1:0];
        w_mem_wdata = wdata;
        w_mem_be    = be;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_clr_ptr;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end else if (w_accept && we && w_in_range) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_accept;
            r_err <= w_accept && !w_in_range;
            if (w_accept && !we) begin
                r_rdata <= w_in_range ? r_mem[addr[c_IDX_W-1:0]] : '0;
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign ready = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench for dmem_ctrl (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              ready;

    int n_assert;
    int n_fail;

    dmem_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .ack   (ack),
        .err   (err),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one request, take the edge, land 1 time unit after it
    task automatic cyc(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [1:0] b);
        req = r; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = 2'b11;
        @(posedge clk); #1; @(posedge clk); #1;
        n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
        n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            n_assert++; if (ready !== (i == DEPTH)) begin n_fail++; $display("FAIL clr_ready edge %0d: got %b want %b", i, ready, (i == DEPTH)); end
            n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL clr_ack edge %0d: got %b want 0", i, ack); end
        end
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, 1'b0, ADDR_W'(k), 16'hDEAD, 2'b11);
            n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL clr_rd_ack addr %0d: got %b want 1", k, ack); end
            n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL clr_rd_data addr %0d: got %h want 0000", k, rdata); end
        end
        cyc(1'b0, 1'b0, '0, '0, 2'b00);
    endtask

    task automatic test_write_read();
        cyc(1'b1, 1'b1, 8'd3, 16'h1234, 2'b11);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", ack); end
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err); end
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 0000", rdata); end
        cyc(1'b1, 1'b0, 8'd3, 16'h0000, 2'b00);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %b want 1", ack); end
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", err); end
        n_assert++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h want 1234", rdata); end
        cyc(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %b want 0", ack); end
        n_assert++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL idle_rdata_hold: got %h want 1234", rdata); end
    endtask

    task automatic test_byte_lanes();
        cyc(1'b1, 1'b1, 8'd5, 16'hFFFF, 2'b11);
        cyc(1'b1, 1'b1, 8'd5, 16'h00AB, 2'b01);
        cyc(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00);
        n_assert++; if (rdata !== 16'hFFAB) begin n_fail++; $display("FAIL lane_lo: got %h want FFAB", rdata); end
        cyc(1'b1, 1'b1, 8'd5, 16'h1111, 2'b00);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL lane_be0_ack: got %b want 1", ack); end
        cyc(1'b1, 1'b1, 8'd5, 16'h55CC, 2'b10);
        cyc(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00);
        n_assert++; if (rdata !== 16'h55AB) begin n_fail++; $display("FAIL lane_hi: got %h want 55AB", rdata); end
    endtask

    task automatic test_out_of_range();
        cyc(1'b1, 1'b1, 8'd9, 16'hBEEF, 2'b11);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL oor_wr_ack: got %b want 1", ack); end
        n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", err); end
        n_assert++; if (rdata !== 16'h55AB) begin n_fail++; $display("FAIL oor_wr_rdata_hold: got %h want 55AB", rdata); end
        cyc(1'b1, 1'b0, 8'd9, 16'h0000, 2'b00);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL oor_rd_ack: got %b want 1", ack); end
        n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", err); end
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0000", rdata); end
        cyc(1'b1, 1'b0, 8'd7, 16'h0000, 2'b00);
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b want 0", err); end
        cyc(1'b1, 1'b0, 8'd8, 16'h0000, 2'b00);
        n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL depth_edge_err: got %b want 1", err); end
        cyc(1'b1, 1'b0, 8'd1, 16'h0000, 2'b00);
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL alias_err: got %b want 0", err); end
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL alias_data: got %h want 0000", rdata); end
        cyc(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d;
        cyc(1'b1, 1'b1, 8'd0, 16'hA000, 2'b11);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack 0: got %b want 1", ack); end
        cyc(1'b1, 1'b1, 8'd1, 16'hB111, 2'b11);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack 1: got %b want 1", ack); end
        cyc(1'b1, 1'b1, 8'd2, 16'hC222, 2'b11);
        n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack 2: got %b want 1", ack); end
        for (int k = 2; k >= 0; k--) begin
            case (k)
                2:       exp_d = 16'hC222;
                1:       exp_d = 16'hB111;
                default: exp_d = 16'hA000;
            endcase
            cyc(1'b1, 1'b0, ADDR_W'(k), 16'h0000, 2'b00);
            n_assert++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ack addr %0d: got %b want 1", k, ack); end
            n_assert++; if (rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rd_data addr %0d: got %h want %h", k, rdata, exp_d); end
        end
        cyc(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
    endtask

    task automatic test_reset_mid_clear();
        // Reset in the ack cycle of a read must drop it immediately
        cyc(1'b1, 1'b0, 8'd2, 16'h0000, 2'b00);
        n_assert++; if (rdata !== 16'hC222) begin n_fail++; $display("FAIL pre_rst_data: got %h want C222", rdata); end
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_assert++; if (ack !== 1'b0) begin n_fail++; $display("FAIL async_rst_ack: got %b want 0", ack); end
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_rst_err: got %b want 0", err); end
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL async_rst_rdata: got %h want 0000", rdata); end
        n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b want 0", ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_assert++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_clr_ready: got %b want 0", ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            n_assert++; if (ready !== (i == DEPTH)) begin n_fail++; $display("FAIL re_clr_ready edge %0d: got %b want %b", i, ready, (i == DEPTH)); end
        end
        cyc(1'b1, 1'b0, 8'd5, 16'h0000, 2'b00);
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL re_clr_data5: got %h want 0000", rdata); end
        cyc(1'b1, 1'b0, 8'd2, 16'h0000, 2'b00);
        n_assert++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL re_clr_data2: got %h want 0000", rdata); end
        cyc(1'b0, 1'b0, 8'd0, 16'h0000, 2'b00);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, clocked data memory for the CPU's MEM stage, replacing the fixed 16-word combinational store. It provides a request/acknowledge port with a registered one-cycle read and byte-lane writes. Writes are write-first, so a read of the address being written returns the new data. After reset it runs an auto-clear sequence that zeroes every word, and it flags accesses beyond the configured depth.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 8, address width in bits (word addressing)
- DEPTH, 256, number of implemented words; 1 ≤ DEPTH ≤ 2^ADDR_W
- INIT_CLEAR, 1, 1 = zero all words after reset; 0 = skip clearing (contents undefined)

- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  access request; sampled only while ready=1
- we  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
- rdata  out  DATA_W  read data; meaningful when ack=1 for a read
- ack  out  1  one-cycle pulse, one clock after an accepted request
- err  out  1  asserted with ack when the accepted addr ≥ DEPTH
- ready  out  1  1 = requests accepted; 0 during auto-clear

## Operation
- State machine: CLEAR, RUN.
  - Reset enters CLEAR if INIT_CLEAR=1, otherwise RUN.
  - CLEAR: a clear pointer runs from 0 to DEPTH-1, writing 0 to one word per cycle. When the pointer reaches DEPTH-1 and that word is written, the state moves to RUN.
  - RUN: the terminal state until the next reset.
- ready is 1 only in RUN. req while ready=0 is ignored: no ack, no memory change.
- A request is accepted when req=1 and ready=1 at a rising edge.
- Accepted write, addr < DEPTH: for each lane i with be[i]=1, mem[addr] lane i ← wdata lane i. Lanes with be[i]=0 are unchanged. be=0 is a legal no-op write that still produces ack.
- Accepted read, addr < DEPTH: rdata ← mem[addr].
- Write-first behaviour covers only the case where a read and a write reach the same address in the same cycle. With a single port this cannot occur, so no forwarding logic is needed. A read accepted the cycle after a write to the same address returns the new data.
- addr ≥ DEPTH:
  - A write modifies nothing.
  - A read returns rdata = 0.
  - Both produce ack=1 and err=1.
- rdata holds its last value until the next accepted read. An accepted write does not change rdata.
- Requests may be back-to-back, one per cycle. There is no backpressure in RUN.

## Timing
- Reset values:
  - rdata = 0, ack = 0, err = 0, clear pointer = 0.
  - ready = 0 if INIT_CLEAR=1, else 1.
  - Memory contents are not reset directly; they are zeroed by CLEAR.
- Clear duration: ready rises exactly DEPTH clock edges after rst_n deasserts (DEPTH=256 gives 256 edges). The first request can be accepted on the following edge.
- Latency: request accepted at edge N gives ack, err and rdata valid in the cycle after edge N, sampled at edge N+1. ack is a single-cycle pulse per accepted request. Consecutive accepted requests give consecutive ack cycles.
- err is 0 whenever ack is 0.
- Reset asserted mid-clear or mid-access:
  - All outputs go immediately to their reset values.
  - An in-flight ack is dropped.
  - Clearing restarts from word 0.
- Address wrap: addr is never truncated modulo DEPTH. Out-of-range handling always applies.

## Test plan
- Reset, INIT_CLEAR=1, DEPTH=8: hold req=1 with we=0. Required: ready=0 for exactly 8 edges after rst_n rises, no ack during that time, then every word reads 0x0000.
- Write addr 3, wdata=0x1234, be=2'b11, then read addr 3 on the next cycle. Required: ack on both cycles, rdata=0x1234 in the read's ack cycle, err=0.
- Byte lanes: write 0xFFFF to addr 5, then write wdata=0x00AB with be=2'b01, then read addr 5. Required: rdata=0xFFAB.
- Out of range, DEPTH=8: write 0xBEEF to addr 9, then read addr 9, then read addr 1. Required: ack=1 and err=1 on the first two, read rdata=0x0000, addr 1 unchanged, err=0 on the third.
- Back-to-back: writes to addr 0, 1, 2, then reads of 2, 1, 0 on consecutive cycles. Required: six consecutive ack pulses, read data in order 2→1→0 matching what was written.
- Reset mid-clear: pull rst_n low at clear pointer 4 of DEPTH=8. Required: ack, err and rdata return to 0 at once, and ready rises 8 edges after the second rst_n release.
